// File: rtl/note_detector.sv
`default_nettype none
// ============================================================================
// Module   : note_detector
// Function : Measures the half-period of an asynchronous square wave and
//            decodes it to a piano note index (1..21 = C3..B5, 0 = silence).
// Revision : 1.0 - initial release
// ============================================================================

module note_detector #(
  parameter int CNT_W      = 21,
  parameter int TIMEOUT    = 2000000,
  parameter int TOL_SHIFT  = 6,
  parameter int STABLE_CNT = 4,
  // Divides the whole note table by 2**HP_SHIFT; 0 gives the real tones.
  parameter int HP_SHIFT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  output logic [6:0]       note,
  output logic             note_strobe,
  output logic             locked,
  output logic [CNT_W-1:0] period
);

  localparam int             c_ext_w        = CNT_W + 1;
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]     c_stable       = 4'(STABLE_CNT);
  localparam logic [3:0]     c_run_max      = 4'd15;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_MEASURE = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_sync1, r_sync2, r_sync3, r_e;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_cand;
  logic [3:0]       r_run;
  logic             r_report;

  logic [CNT_W-1:0] w_m;
  logic [4:0]       w_k;
  logic             w_hit;

  function automatic int note_hp(input int idx);
    case (idx)
      1:  note_hp = 769231;  2:  note_hp = 680273;  3:  note_hp = 606062;
      4:  note_hp = 571429;  5:  note_hp = 510205;  6:  note_hp = 454546;
      7:  note_hp = 404859;  8:  note_hp = 381681;  9:  note_hp = 340137;
      10: note_hp = 303031;  11: note_hp = 285715;  12: note_hp = 255103;
      13: note_hp = 227273;  14: note_hp = 202430;  15: note_hp = 191205;
      16: note_hp = 170358;  17: note_hp = 151746;  18: note_hp = 143267;
      19: note_hp = 127714;  20: note_hp = 113637;  21: note_hp = 101318;
      default: note_hp = 0;
    endcase
  endfunction

  // One extra bit keeps hp + tol from wrapping for any CNT_W-wide value.
  function automatic logic in_window(input logic [c_ext_w-1:0] m, input int idx);
    logic [c_ext_w-1:0] hp, tol;
    hp  = c_ext_w'(note_hp(idx) >> HP_SHIFT);
    tol = hp >> TOL_SHIFT;
    in_window = (m >= hp - tol) && (m <= hp + tol);
  endfunction

  assign w_m   = r_cnt + CNT_W'(1);
  assign w_hit = (r_run >= c_stable);

  // Descending scan so the lowest matching index wins.
  always_comb begin
    w_k = '0;
    for (int i = 21; i >= 1; i--) begin
      if (in_window({1'b0, w_m}, i)) w_k = 5'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync3     <= 1'b0;
      r_e         <= 1'b0;
      r_cnt       <= '0;
      r_cand      <= '0;
      r_run       <= '0;
      r_report    <= 1'b0;
      note        <= '0;
      note_strobe <= 1'b0;
      locked      <= 1'b0;
      period      <= '0;
    end else begin
      r_sync1     <= tone_in;
      r_sync2     <= r_sync1;
      r_sync3     <= r_sync2;
      r_e         <= r_sync2 ^ r_sync3;
      note_strobe <= 1'b0;
      r_report    <= 1'b0;

      if (r_report) begin
        if (w_hit && ({2'b00, r_cand} != note)) begin
          note        <= {2'b00, r_cand};
          note_strobe <= 1'b1;
        end
        locked <= w_hit;
      end

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (r_e) r_state <= S_MEASURE;
        end
        S_MEASURE: begin
          if (r_e) begin
            r_cnt    <= '0;
            period   <= w_m;
            r_report <= 1'b1;
            if (w_k == 5'd0) begin
              r_cand <= '0;
              r_run  <= '0;
              locked <= 1'b0;
            end else if (w_k == r_cand) begin
              r_run <= (r_run == c_run_max) ? c_run_max : r_run + 4'd1;
            end else begin
              r_cand <= w_k;
              r_run  <= 4'd1;
            end
          end else if (r_cnt == c_timeout_last) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cand      <= '0;
            r_run       <= '0;
            locked      <= 1'b0;
            note        <= '0;
            note_strobe <= (note != 7'd0);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_note_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_detector
// Function : Directed bench for note_detector using a scaled note table.
// Revision : 1.0 - initial release
// ============================================================================

module tb_note_detector;

  localparam int CNT_W    = 21;
  localparam int TIMEOUT  = 4000;
  localparam int HP_SHIFT = 8;

  // Scaled table (>>8): E4 1183 window 1165..1201, G4 996 window 981..1011.
  localparam int HP_E4    = 1183;
  localparam int HP_E4_IN = 1198;
  localparam int HP_OUT   = 1207;
  localparam int HP_G4    = 996;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tone_in = 1'b0;
  logic [6:0]       note;
  logic             note_strobe;
  logic             locked;
  logic [CNT_W-1:0] period;

  int n_cmp = 0;
  int n_fail = 0;
  int n_strobe = 0;
  int cyc = 0;
  int last_edge = 0;

  note_detector #(
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT),
    .TOL_SHIFT (6),
    .STABLE_CNT(4),
    .HP_SHIFT  (HP_SHIFT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tone_in    (tone_in),
    .note       (note),
    .note_strobe(note_strobe),
    .locked     (locked),
    .period     (period)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (note_strobe === 1'b1) n_strobe <= n_strobe + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Toggle tone_in n clock edges after the previous toggle.
  task automatic edge_after(input int n);
    while (cyc < last_edge + n) @(negedge clk);
    tone_in   = ~tone_in;
    last_edge = cyc;
  endtask

  task automatic wait_since(input int n);
    while (cyc < last_edge + n) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_note",   32'(note), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_period", 32'(period), 0);
    check("rst_strobe", 32'(note_strobe), 0);

    // Steady E4: first edge opens the window, four measurements lock.
    rst_n = 1'b1;
    last_edge = cyc;
    edge_after(10);
    for (int i = 0; i < 4; i++) edge_after(HP_E4);
    wait_since(4);
    check("e4_note_early", 32'(note), 0);
    wait_since(5);
    check("e4_note",   32'(note), 10);
    check("e4_locked", 32'(locked), 1);
    check("e4_period", 32'(period), HP_E4);
    wait_since(6);
    check("e4_strobes", 32'(n_strobe), 1);

    // Inside the E4 tolerance window: stays locked, no new strobe.
    for (int i = 0; i < 4; i++) edge_after(HP_E4_IN);
    wait_since(5);
    check("win_note",   32'(note), 10);
    check("win_locked", 32'(locked), 1);
    check("win_period", 32'(period), HP_E4_IN);

    // Just outside the window: unlocks, note held.
    edge_after(HP_OUT);
    wait_since(5);
    check("out_locked", 32'(locked), 0);
    check("out_period", 32'(period), HP_OUT);
    for (int i = 0; i < 4; i++) edge_after(HP_OUT);
    wait_since(6);
    check("out_note",    32'(note), 10);
    check("out_locked2", 32'(locked), 0);
    check("out_strobes", 32'(n_strobe), 1);

    // Relock to E4, then switch to G4.
    for (int i = 0; i < 3; i++) edge_after(HP_E4);
    wait_since(5);
    check("relock3_locked", 32'(locked), 0);
    edge_after(HP_E4);
    wait_since(5);
    check("relock4_locked", 32'(locked), 1);
    for (int i = 0; i < 3; i++) edge_after(HP_G4);
    wait_since(5);
    check("g4_3_note",   32'(note), 10);
    check("g4_3_locked", 32'(locked), 0);
    check("g4_3_period", 32'(period), HP_G4);
    edge_after(HP_G4);
    wait_since(4);
    check("g4_4_note_early", 32'(note), 10);
    wait_since(5);
    check("g4_note",   32'(note), 12);
    check("g4_locked", 32'(locked), 1);
    wait_since(6);
    check("g4_strobes", 32'(n_strobe), 2);

    // Silence: timeout counted from the last edge pulse.
    wait_since(4 + TIMEOUT - 1);
    check("sil_before", 32'(note), 12);
    wait_since(4 + TIMEOUT);
    check("sil_note",   32'(note), 0);
    check("sil_locked", 32'(locked), 0);
    check("sil_period", 32'(period), HP_G4);
    wait_since(4 + TIMEOUT + 2);
    check("sil_strobes", 32'(n_strobe), 3);
    edge_after(50);
    wait_since(10);
    check("first_edge_period", 32'(period), HP_G4);
    check("first_edge_note",   32'(note), 0);

    // E4 stream with a short glitch.
    for (int i = 0; i < 4; i++) edge_after(HP_E4);
    wait_since(6);
    check("gl_pre_note",    32'(note), 10);
    check("gl_pre_locked",  32'(locked), 1);
    check("gl_pre_strobes", 32'(n_strobe), 4);
    edge_after(100);
    wait_since(5);
    check("gl_locked", 32'(locked), 0);
    check("gl_period", 32'(period), 100);
    edge_after(HP_E4 - 100);
    wait_since(5);
    check("gl_rest_period", 32'(period), HP_E4 - 100);
    for (int i = 0; i < 3; i++) edge_after(HP_E4);
    wait_since(5);
    check("gl_3_locked", 32'(locked), 0);
    edge_after(HP_E4);
    wait_since(5);
    check("gl_4_locked", 32'(locked), 1);
    check("gl_4_note",   32'(note), 10);
    wait_since(6);
    check("gl_strobes", 32'(n_strobe), 4);

    // Reset in the middle of a measurement.
    wait_since(300);
    rst_n   = 1'b0;
    tone_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_note",   32'(note), 0);
    check("mid_rst_locked", 32'(locked), 0);
    check("mid_rst_period", 32'(period), 0);
    check("mid_rst_strobe", 32'(note_strobe), 0);
    last_edge = cyc;
    edge_after(20);
    wait_since(10);
    check("post_rst_open_period", 32'(period), 0);
    edge_after(HP_E4);
    wait_since(5);
    check("post_rst_period", 32'(period), HP_E4);
    check("post_rst_note",   32'(note), 0);
    wait_since(8);
    check("post_rst_strobes", 32'(n_strobe), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
